// File: rtl/tinyalu_pkg.sv
// Shared types and constants for the memory interface unit.
// Contents: mif_state_t FSM encoding, memory width constants, default error byte,
//           and a helper that picks which store byte goes out on each write beat.
package tinyalu_pkg;

  localparam int         MEM_AW           = 14;
  localparam int         MEM_DW           = 8;
  localparam logic [7:0] ERR_DATA_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_LO,
    WR_HI,
    DONE
  } mif_state_t;

  // Byte written on a given beat: beat 0 targets addr, beat 1 targets addr+1.
  // Little-endian puts word[7:0] on beat 0; big-endian swaps the halves.
  function automatic logic [7:0] store_byte(input logic [15:0] word,
                                            input logic        second_beat,
                                            input logic        big_endian);
    return (second_beat ^ big_endian) ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/mem_if_timer.sv
// Read-wait timer: 8-bit counter, synchronous clear (priority) and count enable.
// Ports: clk, reset_n (async active-low), clr, en in; expired out (combinational).
// expired is high while count == TIMEOUT-1, i.e. in the TIMEOUT-th enabled cycle.
module mem_if_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // Counting starts at 0 on the first wait cycle, so matching TIMEOUT-1 flags
  // the last allowed cycle and the FSM leaves after exactly TIMEOUT cycles.
  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_interface_unit.sv
// Bridges load/store requests to a byte-wide req/gnt/rvalid memory: 1 read per load, 2 writes per store.
// Latency: request sampled in IDLE, mem_done 3 cycles later with gnt high and rvalid one cycle after grant.
// Backpressure: mem_req/addr/wdata held stable until mem_gnt; reads abort after TIMEOUT wait cycles.
// Ports: clk, reset_n, load, store, addr, result, err_clr in; data, mem_done, err out;
//        mem_req, mem_we, mem_addr, mem_wdata out and mem_gnt, mem_rvalid, mem_rdata in to memory.
module mem_interface_unit
  import tinyalu_pkg::*;
#(
  parameter int         ADDR_W     = MEM_AW,
  parameter int         TIMEOUT    = 16,
  parameter logic [7:0] ERR_DATA   = ERR_DATA_DEFAULT,
  parameter bit         BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       result,
  output logic [MEM_DW-1:0] data,
  output logic              mem_done,
  output logic              err,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [MEM_DW-1:0] mem_rdata
);

  mif_state_t        state;
  logic [ADDR_W-1:0] cap_addr;
  logic [15:0]       cap_result;
  logic              timer_clr;
  logic              timer_en;
  logic              timer_expired;

  // Timer restarts on the grant that moves us into RD_WAIT, then runs only there.
  assign timer_clr = (state == RD_REQ) && mem_gnt;
  assign timer_en  = (state == RD_WAIT);

  mem_if_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  // Memory-side outputs are loaded on the transition into each state so they
  // are already valid (and stay stable) during the first cycle of that state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cap_addr   <= '0;
      cap_result <= '0;
      data       <= '0;
      mem_done   <= 1'b0;
      err        <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_done <= 1'b0;
      // Clear first; any error raised below in the same cycle overrides it.
      if (err_clr) err <= 1'b0;

      case (state)
        IDLE: begin
          cap_addr   <= addr;
          cap_result <= result;
          if (load) begin
            // load wins a load&store collision; the collision itself is an error.
            if (store) err <= 1'b1;
            state    <= RD_REQ;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= addr;
          end else if (store) begin
            state     <= WR_LO;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= store_byte(result, 1'b0, BIG_ENDIAN);
          end
        end

        RD_REQ: begin
          if (mem_gnt) begin
            state   <= RD_WAIT;
            mem_req <= 1'b0;
          end
        end

        RD_WAIT: begin
          // rvalid is checked first so a response in the expiry cycle is not an error.
          if (mem_rvalid) begin
            data     <= mem_rdata;
            state    <= DONE;
            mem_done <= 1'b1;
          end else if (timer_expired) begin
            data     <= ERR_DATA;
            err      <= 1'b1;
            state    <= DONE;
            mem_done <= 1'b1;
          end
        end

        WR_LO: begin
          if (mem_gnt) begin
            state     <= WR_HI;
            mem_addr  <= cap_addr + ADDR_W'(1);  // wraps at the top of memory
            mem_wdata <= store_byte(cap_result, 1'b1, BIG_ENDIAN);
          end
        end

        WR_HI: begin
          if (mem_gnt) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_done <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed bench for mem_interface_unit: little-endian DUT plus a big-endian twin on the same stimulus.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_mem_interface_unit;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic        store;
  logic [13:0] addr;
  logic [15:0] result;
  logic        err_clr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;

  logic [7:0]  data;
  logic        mem_done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [13:0] mem_addr;
  logic [7:0]  mem_wdata;

  logic [7:0]  be_data;
  logic        be_mem_done;
  logic        be_err;
  logic        be_mem_req;
  logic        be_mem_we;
  logic [13:0] be_mem_addr;
  logic [7:0]  be_mem_wdata;

  int n_vec  = 0;
  int n_fail = 0;

  mem_interface_unit #(.BIG_ENDIAN(1'b0)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .result     (result),
    .data       (data),
    .mem_done   (mem_done),
    .err        (err),
    .err_clr    (err_clr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  mem_interface_unit #(.BIG_ENDIAN(1'b1)) u_dut_be (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .store      (store),
    .addr       (addr),
    .result     (result),
    .data       (be_data),
    .mem_done   (be_mem_done),
    .err        (be_err),
    .err_clr    (err_clr),
    .mem_req    (be_mem_req),
    .mem_we     (be_mem_we),
    .mem_addr   (be_mem_addr),
    .mem_wdata  (be_mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;

    reset_n = 1'b0; load = 1'b0; store = 1'b0; addr = '0; result = '0;
    err_clr = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_req",   16'(mem_req),   16'h0);
    chk("rst_we",    16'(mem_we),    16'h0);
    chk("rst_addr",  16'(mem_addr),  16'h0);
    chk("rst_wdata", 16'(mem_wdata), 16'h0);
    chk("rst_data",  16'(data),      16'h0);
    chk("rst_done",  16'(mem_done),  16'h0);
    chk("rst_err",   16'(err),       16'h0);
    reset_n = 1'b1;
    tick();

    // ---- store 0xBEEF @ 0x0010, gnt high ----
    store = 1'b1; addr = 14'h0010; result = 16'hBEEF; mem_gnt = 1'b1;
    tick();
    store = 1'b0; addr = 14'h1111; result = 16'h5555;  // must be ignored mid-op
    chk("st_lo_req",   16'(mem_req),      16'h1);
    chk("st_lo_we",    16'(mem_we),       16'h1);
    chk("st_lo_addr",  16'(mem_addr),     16'h0010);
    chk("st_lo_wdat",  16'(mem_wdata),    16'h00EF);
    chk("st_lo_bedat", 16'(be_mem_wdata), 16'h00BE);
    tick();
    chk("st_hi_addr",  16'(mem_addr),     16'h0011);
    chk("st_hi_wdat",  16'(mem_wdata),    16'h00BE);
    chk("st_hi_bedat", 16'(be_mem_wdata), 16'h00EF);
    chk("st_hi_done",  16'(mem_done),     16'h0);
    tick();
    chk("st_done",     16'(mem_done),     16'h1);
    chk("st_done_req", 16'(mem_req),      16'h0);
    chk("st_data",     16'(data),         16'h0);
    tick();
    chk("st_done_1cy", 16'(mem_done),     16'h0);

    // ---- store wrap 0x1234 @ 0x3FFF ----
    store = 1'b1; addr = 14'h3FFF; result = 16'h1234;
    tick();
    store = 1'b0;
    chk("wr_lo_addr", 16'(mem_addr),  16'h3FFF);
    chk("wr_lo_wdat", 16'(mem_wdata), 16'h0034);
    tick();
    chk("wr_hi_addr", 16'(mem_addr),  16'h0000);
    chk("wr_hi_wdat", 16'(mem_wdata), 16'h0012);
    tick();
    chk("wr_done",    16'(mem_done),  16'h1);
    tick();

    // ---- load 0x0123 with 3 gnt stall cycles, rvalid 2 cycles after gnt ----
    load = 1'b1; addr = 14'h0123; mem_gnt = 1'b0;
    tick();
    load = 1'b0; addr = 14'h2222;
    for (int i = 0; i < 3; i++) begin
      chk("ld_stall_req",  16'(mem_req),  16'h1);
      chk("ld_stall_addr", 16'(mem_addr), 16'h0123);
      chk("ld_stall_we",   16'(mem_we),   16'h0);
      tick();
    end
    chk("ld_stall_req3", 16'(mem_req), 16'h1);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("ld_wait_req", 16'(mem_req),  16'h0);
    tick();
    chk("ld_wait_done", 16'(mem_done), 16'h0);
    mem_rvalid = 1'b1; mem_rdata = 8'h5A;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    chk("ld_done", 16'(mem_done), 16'h1);
    chk("ld_data", 16'(data),     16'h005A);
    tick();
    chk("ld_done_1cy", 16'(mem_done), 16'h0);
    chk("ld_data_hold", 16'(data),    16'h005A);

    // ---- timeout: rvalid never arrives ----
    load = 1'b1; addr = 14'h0200; mem_gnt = 1'b1;
    tick();
    load = 1'b0;
    tick();                        // now in first RD_WAIT cycle
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!mem_done && cnt < 40);
    chk("to_cycles", 16'(cnt),  16'd16);
    chk("to_data",   16'(data), 16'h00FF);
    chk("to_err",    16'(err),  16'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h77;  // late response in IDLE
    tick(); tick();
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    chk("late_data", 16'(data),     16'h00FF);
    chk("late_done", 16'(mem_done), 16'h0);
    chk("late_req",  16'(mem_req),  16'h0);
    chk("err_sticky", 16'(err),     16'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_clr", 16'(err), 16'h0);

    // ---- rvalid in the expiry cycle: rvalid wins ----
    load = 1'b1; addr = 14'h0300;
    tick();
    load = 1'b0;
    tick();                        // first RD_WAIT cycle
    for (int i = 0; i < 15; i++) tick();
    chk("race_nodone", 16'(mem_done), 16'h0);
    mem_rvalid = 1'b1; mem_rdata = 8'h3C;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 8'h00;
    chk("race_done", 16'(mem_done), 16'h1);
    chk("race_data", 16'(data),     16'h003C);
    chk("race_err",  16'(err),      16'h0);
    tick();

    // ---- load&store collision, load held across DONE ----
    load = 1'b1; store = 1'b1; addr = 14'h0002;
    tick();
    store = 1'b0;
    chk("col_req",  16'(mem_req),  16'h1);
    chk("col_we",   16'(mem_we),   16'h0);
    chk("col_addr", 16'(mem_addr), 16'h0002);
    chk("col_err",  16'(err),      16'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h11;
    tick();
    mem_rvalid = 1'b0;
    chk("b2b_done1", 16'(mem_done), 16'h1);
    chk("b2b_data1", 16'(data),     16'h0011);
    tick();
    chk("b2b_idle_done", 16'(mem_done), 16'h0);
    tick();
    chk("b2b_req2", 16'(mem_req), 16'h1);
    load = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h22;
    tick();
    mem_rvalid = 1'b0;
    chk("b2b_done2", 16'(mem_done), 16'h1);
    chk("b2b_data2", 16'(data),     16'h0022);
    tick();

    // ---- err_clr together with a new collision error: error wins ----
    err_clr = 1'b1; load = 1'b1; store = 1'b1; addr = 14'h0004;
    tick();
    err_clr = 1'b0; load = 1'b0; store = 1'b0;
    chk("clr_vs_err", 16'(err), 16'h1);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 8'h44;
    tick();
    mem_rvalid = 1'b0;
    tick();

    // ---- reset in WR_HI aborts the store ----
    store = 1'b1; addr = 14'h0100; result = 16'hABCD; mem_gnt = 1'b0;
    tick();
    store = 1'b0; mem_gnt = 1'b1;
    tick();
    chk("mid_wrhi_addr", 16'(mem_addr), 16'h0101);
    reset_n = 1'b0;
    #1;
    chk("arst_req",   16'(mem_req),   16'h0);
    chk("arst_we",    16'(mem_we),    16'h0);
    chk("arst_addr",  16'(mem_addr),  16'h0);
    chk("arst_wdata", 16'(mem_wdata), 16'h0);
    chk("arst_data",  16'(data),      16'h0);
    chk("arst_err",   16'(err),       16'h0);
    tick();
    reset_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_done", 16'(mem_done), 16'h0);
      chk("post_rst_req",  16'(mem_req),  16'h0);
      chk("post_rst_data", 16'(data),     16'h0);
    end
    mem_rvalid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_interface_unit.md
Name: mem_interface_unit

Overview:
- Sits directly downstream of the instruction unit, between it and byte-wide main memory.
- Accepts level load/store requests with a 14-bit address and 16-bit ALU result.
- Runs a req/gnt/rvalid handshake to memory: one byte read per load, two byte writes per store.
- Returns read data plus a one-cycle mem_done pulse. Includes a read timeout and a sticky error flag.

Parameters:
ADDR_W, 14, memory address width.
TIMEOUT, 16, max cycles spent in RD_WAIT before aborting a read (valid range 1..255).
ERR_DATA, 8'hFF, byte returned on read timeout.
BIG_ENDIAN, 0, 0 = result[7:0] at addr and result[15:8] at addr+1; 1 = swapped.

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
load  in  1  load request from instruction unit (level)
store  in  1  store request from instruction unit (level)
addr  in  ADDR_W  request address
result  in  16  store data
data  out  8  last loaded byte
mem_done  out  1  one-cycle completion pulse
err  out  1  sticky error: timeout or load&store together
err_clr  in  1  synchronous clear of err
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read (qualified by mem_req)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  write byte
mem_gnt  in  1  memory accepts the request in any cycle where mem_req & mem_gnt
mem_rvalid  in  1  read data valid
mem_rdata  in  8  read data

Behaviour:
- Reset is asynchronous: data=0, mem_done=0, err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, timer=0.
- Reset mid-operation aborts immediately. No mem_done is produced. A mem_rvalid arriving after reset is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_LO, WR_HI, DONE.
- IDLE:
  - Samples load/store and captures addr/result into internal registers.
  - load → RD_REQ; store → WR_LO.
  - load&store both high → treated as load and err set.
  - mem_rvalid in IDLE is ignored.
- RD_REQ: mem_req=1, mem_we=0, mem_addr=captured addr. Hold until mem_gnt, then → RD_WAIT with timer cleared.
- RD_WAIT: mem_req=0, timer increments each cycle.
  - mem_rvalid: data←mem_rdata, → DONE.
  - Timer reaches TIMEOUT without rvalid: data←ERR_DATA, err set, → DONE.
  - rvalid and timeout in the same cycle: rvalid wins, no error.
- WR_LO: mem_req=1, mem_we=1, addr and low/high byte per BIG_ENDIAN. Hold until mem_gnt → WR_HI.
- WR_HI: mem_req=1, mem_we=1, mem_addr=addr+1 modulo 2^ADDR_W (3FFF wraps to 0000), other byte. mem_gnt → DONE.
- DONE: mem_done=1 for exactly one cycle, mem_req=0, → IDLE.
  - Upstream must change or drop its request during this cycle; a request still held is sampled again in IDLE as a new operation.
- Request signals are sampled only in IDLE. Changes during an operation are ignored (captured copies are used).
- mem_req, mem_we, mem_addr and mem_wdata are registered outputs and stable while waiting for gnt.
- data changes only when a load completes. A store leaves data unchanged.
- err_clr clears err. err_clr and a new error in the same cycle: error wins.
- Latency with gnt tied high and rvalid one cycle after grant:
  - Load: request seen in cycle 0, mem_done in cycle 3.
  - Store: request seen in cycle 0, mem_done in cycle 3.

Decomposition:
- tinyalu_pkg gains:
  - mif_state_t enum (the six states above).
  - Constants MEM_AW=14 and MEM_DW=8.
  - Default ERR_DATA value.
- One natural sub-module: mem_if_timer, an 8-bit clearable, enableable counter with an expired flag compared against TIMEOUT.
- The FSM, capture registers and output registers stay in mem_interface_unit.

Test Plan:
1. Reset mid-store: assert reset_n=0 while in WR_HI → all outputs 0 immediately; after release no mem_done and no write of the high byte.
2. Store: addr=0x0010, result=0xBEEF, gnt=1 → writes 0xEF@0x0010 then 0xBE@0x0011 on consecutive cycles; mem_done pulse 1 cycle; data unchanged. BIG_ENDIAN=1 → 0xBE@0x0010, 0xEF@0x0011.
3. Load with stalls: addr=0x0123, gnt low 3 cycles, rvalid 2 cycles after gnt with rdata=0x5A → mem_req held with addr stable until gnt; data=0x5A at mem_done; exactly one done pulse.
4. Wrap: store addr=0x3FFF, result=0x1234 → 0x34@0x3FFF, 0x12@0x0000.
5. Timeout: load, gnt=1, rvalid never asserted → mem_done exactly TIMEOUT cycles after entering RD_WAIT, data=0xFF, err=1 until err_clr; a late rvalid in IDLE has no effect.
6. Protocol error / back-to-back: load=store=1 at addr 0x0002 → read performed and err=1. Load held high across DONE → second read issued, two mem_done pulses.
